fir_coef_loader: RTL and testbench
==================================

# fir_coef_loader

Run-time coefficient configurator for the FIR filter: accepts `ORDER+1` coefficient words over a valid/ready serial port into a shadow bank. It commits the bank atomically onto the filter's `b` bus, but only in a cycle where the filter is not accepting a sample. It sits between the host/data_maker side and the `b` input of `fir_filter`, replacing a static coefficient bus.

## Interface

Parameters:
- `NB`, 13, coefficient/sample word width
- `ORDER`, 10, filter order; `ORDER+1` coefficients per load
- `TOT`, `(ORDER+1)*NB`, width of the coefficient bus (derived, not overridden)

Ports:
- `CLK`  in  1  single clock, rising edge
- `RST_n`  in  1  reset, asynchronous, active-low
- `LD_START`  in  1  one-cycle request to begin a new load sequence
- `LD_VALID`  in  1  `LD_DATA` valid
- `LD_DATA`  in  NB  coefficient word, two's complement
- `LD_READY`  out  1  loader accepts a word this cycle
- `VIN`  in  1  monitor of the filter's input-valid; commit is blocked while high
- `b`  out  TOT  active coefficient bus to `fir_filter`; word k at `b[(k+1)*NB-1 : k*NB]`
- `BUSY`  out  1  high in any state other than IDLE
- `DONE`  out  1  one-cycle pulse after a commit
- `ERR`  out  1  one-cycle pulse when a load in progress is aborted by `LD_START`

## Operation

- Reset values: all outputs 0, state IDLE, index 0, active and shadow banks all 0.
- FSM states: IDLE, LOAD, WAIT_GAP.
- IDLE: `LD_START`=1 -> LOAD with index 0. `LD_VALID` is ignored.
- LOAD: `LD_READY`=1 (Moore, decoded from state).
  - Each `LD_VALID & LD_READY` edge writes `LD_DATA` into shadow word[index] and increments index.
  - The accept at index=`ORDER` moves to WAIT_GAP.
- WAIT_GAP: `LD_READY`=0. At the first edge with `VIN`=0, all shadow words are copied to `b` in one edge, the FSM returns to IDLE and `DONE` pulses in the following cycle. WAIT_GAP has no timeout.
- `LD_START` in LOAD or WAIT_GAP:
  - `ERR` pulses in the next cycle.
  - The FSM goes to LOAD with index 0.
  - The shadow bank is not cleared but is overwritten by the new sequence.
  - `b` is unchanged.
- `LD_START` and `LD_VALID` in the same LOAD cycle: start wins and the word is discarded.
- `b` changes only on a commit edge, so `fir_filter` never sees a partially written bank and never sees a coefficient change on an edge where `VIN`=1.
- Index counter width is `ceil(log2(ORDER+1))`. It never exceeds `ORDER`, with no wrap.
- No arithmetic on data: words are stored bit-exact.

## Timing

- `LD_START` at edge t -> `LD_READY`=1 and `BUSY`=1 from cycle t+1.
- Throughput in LOAD: 1 word/cycle. Minimum load is `ORDER+1` cycles.
- Last accept at edge e -> `LD_READY`=0 from cycle e+1.
- Commit edge: earliest is e+1, if `VIN`=0 at edge e+1.
  - New `b` visible from the commit edge.
  - `DONE`=1 for exactly the cycle after the commit edge.
  - `BUSY`=0 in that same cycle.
- `LD_START` in the cycle right after commit (IDLE, `DONE`=1): normal start, no `ERR`.
- Asynchronous reset mid-load or mid-wait:
  - Outputs go to their reset values immediately, including `b`=0.
  - The shadow bank is cleared.
  - No `DONE`/`ERR` pulse on release.

## Test plan

- Reset then load with `VIN`=0 and words 1..11 back-to-back -> word k=k+1 at `b[13k+12:13k]`; commit at the edge after the 11th accept; `DONE` one cycle; `BUSY` low with `DONE`.
- Load with `LD_VALID` gapped (every other cycle) and words -4096, 4095, 0, … -> exact bit patterns 13'h1000, 13'h0FFF stored; `LD_READY` stays high through the gaps.
- Hold `VIN`=1 for 20 cycles after the last accept -> `b` unchanged and `BUSY`=1 throughout; commit on the first edge with `VIN`=0.
- `LD_START` after 5 accepted words, then 11 new words -> `ERR` one cycle; `b` keeps old bank until commit of the 11 new words only.
- Assert `RST_n`=0 while in WAIT_GAP -> `b`=0, `LD_READY`/`BUSY`/`DONE`/`ERR`=0 immediately; subsequent full load behaves as the first scenario.
- Connected to `fir_filter` with an impulse stream and a coefficient swap mid-stream -> `DOUT` impulse responses switch cleanly from old to new set with no mixed-coefficient output.

Source files
------------

// File: rtl/fir_coef_loader.sv
// ============================================================================
// fir_coef_loader
// Serial coefficient loader with a shadow bank committed atomically to b.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_coef_loader #(
    parameter int NB              = 13,
    parameter int ORDER           = 10,
    localparam int TOT            = (ORDER + 1) * NB
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              LD_START,
    input  logic              LD_VALID,
    input  logic [NB-1:0]     LD_DATA,
    output logic              LD_READY,
    input  logic              VIN,
    output logic [TOT-1:0]    b,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int IW = (ORDER > 0) ? $clog2(ORDER + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_LOAD     = 2'd1,
        S_WAIT_GAP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            w_wr_en;
    logic            w_commit;
    logic [NB-1:0]   shadow_q [0:ORDER];
    logic [NB-1:0]   bank_q   [0:ORDER];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        w_wr_en  = 1'b0;
        w_commit = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (LD_START) begin
                    state_d = S_LOAD;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                // A restart takes priority over a word offered in the same cycle
                if (LD_START) begin
                    err_d = 1'b1;
                    idx_d = '0;
                end else if (LD_VALID) begin
                    w_wr_en = 1'b1;
                    if (idx_q == IW'(ORDER)) begin
                        state_d = S_WAIT_GAP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WAIT_GAP: begin
                if (LD_START) begin
                    err_d   = 1'b1;
                    state_d = S_LOAD;
                    idx_d   = '0;
                end else if (!VIN) begin
                    w_commit = 1'b1;
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int k = 0; k <= ORDER; k++) begin
                shadow_q[k] <= '0;
                bank_q[k]   <= '0;
            end
        end else begin
            if (w_wr_en) begin
                shadow_q[idx_q] <= LD_DATA;
            end
            // Whole bank moves in one edge so the filter never sees a mix
            if (w_commit) begin
                for (int k = 0; k <= ORDER; k++) begin
                    bank_q[k] <= shadow_q[k];
                end
            end
        end
    end

    for (genvar k = 0; k <= ORDER; k++) begin : g_pack
        assign b[k*NB +: NB] = bank_q[k];
    end

    assign LD_READY = (state_q == S_LOAD);
    assign BUSY     = (state_q != S_IDLE);
    assign DONE     = done_q;
    assign ERR      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_coef_loader.sv
// ============================================================================
// tb_fir_coef_loader
// Self-checking bench: per-cycle model comparison plus literal expectations.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fir_coef_loader;

    localparam int NB    = 13;
    localparam int ORDER = 10;
    localparam int NW    = ORDER + 1;
    localparam int TOT   = NW * NB;

    logic            CLK = 1'b0;
    logic            RST_n;
    logic            LD_START;
    logic            LD_VALID;
    logic [NB-1:0]   LD_DATA;
    logic            LD_READY;
    logic            VIN;
    logic [TOT-1:0]  b;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    int checks   = 0;
    int failures = 0;

    fir_coef_loader #(.NB(NB), .ORDER(ORDER)) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .LD_START (LD_START),
        .LD_VALID (LD_VALID),
        .LD_DATA  (LD_DATA),
        .LD_READY (LD_READY),
        .VIN      (VIN),
        .b        (b),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .ERR      (ERR)
    );

    always #5 CLK = ~CLK;

    // Reference behaviour: count of accepted words, a pending-commit flag,
    // and the two banks as plain arrays.
    bit            m_loading, m_pending, m_done, m_err;
    int            m_cnt;
    logic [NB-1:0] m_shadow [NW];
    logic [NB-1:0] m_active [NW];

    always @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            m_loading <= 0; m_pending <= 0; m_done <= 0; m_err <= 0; m_cnt <= 0;
            for (int i = 0; i < NW; i++) begin
                m_shadow[i] <= '0;
                m_active[i] <= '0;
            end
        end else begin
            m_done <= 0;
            m_err  <= 0;
            if (LD_START) begin
                m_err     <= m_loading || m_pending;
                m_loading <= 1;
                m_pending <= 0;
                m_cnt     <= 0;
            end else if (m_loading && LD_VALID) begin
                m_shadow[m_cnt] <= LD_DATA;
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == NW) begin
                    m_loading <= 0;
                    m_pending <= 1;
                end
            end else if (m_pending && !VIN) begin
                m_active  <= m_shadow;
                m_pending <= 0;
                m_done    <= 1;
            end
        end
    end

    function automatic logic [TOT-1:0] model_bus();
        logic [TOT-1:0] v;
        for (int i = 0; i < NW; i++) v[i*NB +: NB] = m_active[i];
        return v;
    endfunction

    task automatic ck(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        ck("ready", TOT'(LD_READY), TOT'(m_loading));
        ck("busy",  TOT'(BUSY),     TOT'(m_loading | m_pending));
        ck("done",  TOT'(DONE),     TOT'(m_done));
        ck("err",   TOT'(ERR),      TOT'(m_err));
        ck("b",     b,              model_bus());
    end

    logic [NB-1:0] wv [NW];

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic start_pulse();
        LD_START = 1;
        step();
        LD_START = 0;
    endtask

    task automatic send_words(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            LD_VALID = 1;
            LD_DATA  = wv[i];
            step();
            if (gap) begin
                LD_VALID = 0;
                LD_DATA  = 13'h0AAA;
                step();
            end
        end
        LD_VALID = 0;
    endtask

    task automatic check_seq_bank();
        for (int k = 0; k < NW; k++)
            ck("word_k_plus_1", TOT'(b[k*NB +: NB]), TOT'(k + 1));
    endtask

    logic [TOT-1:0] saved_b;

    initial begin
        RST_n = 0; LD_START = 0; LD_VALID = 0; LD_DATA = '0; VIN = 0;
        step(); step();
        ck("reset_b", b, '0);
        ck("reset_busy", TOT'(BUSY), '0);
        RST_n = 1;
        step();

        // Sequential words, VIN low: commit one edge after last accept
        for (int i = 0; i < NW; i++) wv[i] = NB'(i + 1);
        start_pulse();
        ck("ready_after_start", TOT'(LD_READY), TOT'(1));
        send_words(NW, 0);
        ck("wait_no_ready", TOT'(LD_READY), '0);
        ck("wait_busy", TOT'(BUSY), TOT'(1));
        step();
        ck("done_pulse", TOT'(DONE), TOT'(1));
        ck("busy_low_with_done", TOT'(BUSY), '0);
        check_seq_bank();

        // Start in the DONE cycle: gapped load with extreme values
        wv[0] = 13'h1000; wv[1] = 13'h0FFF; wv[2] = 13'h0000;
        for (int i = 3; i < NW; i++) wv[i] = NB'(i - 2);
        start_pulse();
        ck("no_err_after_done", TOT'(ERR), '0);
        send_words(NW, 1);
        step();
        ck("min_neg", TOT'(b[12:0]), TOT'(13'h1000));
        ck("max_pos", TOT'(b[25:13]), TOT'(13'h0FFF));
        ck("last_word", TOT'(b[TOT-1 -: NB]), TOT'(8));

        // VIN held high blocks commit
        saved_b = b;
        for (int i = 0; i < NW; i++) wv[i] = NB'(100 + i);
        start_pulse();
        VIN = 1;
        send_words(NW, 0);
        for (int i = 0; i < 20; i++) step();
        ck("blocked_b", b, saved_b);
        ck("blocked_busy", TOT'(BUSY), TOT'(1));
        VIN = 0;
        step();
        ck("commit_after_vin", TOT'(DONE), TOT'(1));
        ck("new_word0", TOT'(b[12:0]), TOT'(100));

        // Restart mid-load: ERR, old bank kept until new commit
        saved_b = b;
        for (int i = 0; i < NW; i++) wv[i] = NB'(13'h1F00 + i);
        start_pulse();
        send_words(5, 0);
        for (int i = 0; i < NW; i++) wv[i] = NB'(200 + i);
        LD_START = 1;
        LD_VALID = 1;
        LD_DATA  = 13'h1234;
        step();
        LD_START = 0;
        LD_VALID = 0;
        ck("restart_err", TOT'(ERR), TOT'(1));
        ck("restart_b_kept", b, saved_b);
        send_words(NW, 0);
        step();
        ck("restart_word0", TOT'(b[12:0]), TOT'(200));
        ck("restart_word10", TOT'(b[TOT-1 -: NB]), TOT'(210));

        // Async reset while waiting for a gap
        start_pulse();
        VIN = 1;
        send_words(NW, 0);
        step();
        #1 RST_n = 0;
        #1;
        ck("areset_b", b, '0);
        ck("areset_ready", TOT'(LD_READY), '0);
        ck("areset_busy", TOT'(BUSY), '0);
        ck("areset_done", TOT'(DONE), '0);
        ck("areset_err", TOT'(ERR), '0);
        step();
        RST_n = 1;
        VIN = 0;
        step();
        ck("release_no_done", TOT'(DONE), '0);
        ck("release_no_err", TOT'(ERR), '0);
        for (int i = 0; i < NW; i++) wv[i] = NB'(i + 1);
        start_pulse();
        send_words(NW, 0);
        step();
        ck("done_after_reset", TOT'(DONE), TOT'(1));
        check_seq_bank();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
